// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t  : control FSM states (IDLE, RUN, DONE)
//   SUB_HALF : SUB_TYPE value for half-subtractor mode (initial borrow forced to 0)
//   SUB_FULL : SUB_TYPE value for full-subtractor mode (initial borrow from bin)
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SUB_HALF = 0;
  localparam int SUB_FULL = 1;

endpackage

// File: rtl/fs_cell.sv
// Combinational 1-bit full subtractor: computes x - y - bi.
// Ports:
//   x  : minuend bit
//   y  : subtrahend bit
//   bi : borrow in
//   d  : difference bit
//   bo : borrow out
module fs_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - borrow_in one bit per clock, LSB first.
// Parameters:
//   WIDTH    : operand/result width (1..64)
//   SUB_TYPE : SUB_HALF (borrow-in forced 0) or SUB_FULL (borrow-in from bin)
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : operand handshake (a, b, bin)
//   out_valid/out_ready : result handshake (diff, bout)
//   diff, bout          : registered difference and final borrow-out
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. in_ready is high only in IDLE and out_valid only in DONE, so exactly one
// operation is in flight; diff/bout are updated once per operation and hold
// their value through DONE and afterwards until the next result is produced.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SUB_TYPE = SUB_FULL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  // Counter must be able to reach WIDTH without wrapping.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] a_sh;    // minuend shifts out at the bottom, difference shifts in at the top
  logic [WIDTH-1:0] b_sh;
  logic            br;       // borrow carried between bit positions
  logic            seed;
  logic            cell_d;
  logic            cell_bo;
  logic [WIDTH-1:0] a_next;

  fs_cell u_cell (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .bi (br),
    .d  (cell_d),
    .bo (cell_bo)
  );

  assign seed = (SUB_TYPE == SUB_FULL) ? bin : 1'b0;

  // Reusing the minuend register as the result shifter: after WIDTH shifts
  // every minuend bit has been consumed and the register holds the difference.
  // The WIDTH+1 wide shift keeps this legal for WIDTH=1.
  assign a_next = WIDTH'({cell_d, a_sh} >> 1);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      br    <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            br    <= seed;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh <= a_next;
          b_sh <= b_sh >> 1;
          br   <= cell_bo;
          cnt  <= cnt + ONE;
          if (cnt == LAST) begin
            // Publish the complete result in one step so diff/bout never
            // show partial values.
            diff  <= a_next;
            bout  <= cell_bo;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 1..64).
REQ-002 SHALL have parameter SUB_TYPE, default 1; 0 = half-subtractor mode (borrow-in forced 0), 1 = full-subtractor mode (borrow-in taken from bin).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operands a, b, bin valid.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port a  input  WIDTH  minuend.
REQ-008 SHALL have port b  input  WIDTH  subtrahend.
REQ-009 SHALL have port bin  input  1  borrow-in; ignored when SUB_TYPE=0.
REQ-010 SHALL have port out_valid  output  1  diff/bout valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port diff  output  WIDTH  difference.
REQ-013 SHALL have port bout  output  1  final borrow-out.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 In IDLE: in_ready=1, out_valid=0. A transfer occurs on a clock edge where in_valid=1 and in_ready=1. That edge captures a, b and initial borrow (bin if SUB_TYPE=1, else 0), clears the bit counter, and moves to RUN.
REQ-016 In RUN: in_ready=0, out_valid=0; in_valid and operands are ignored.
REQ-017 Each RUN cycle processes exactly one bit, LSB first, via the 1-bit cell:
  - d = a_i ^ b_i ^ br
  - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br)
  - d is shifted into the result register, br_next is registered, and the counter is incremented.
REQ-018 After bit WIDTH-1 is processed, the FSM SHALL enter DONE.
  - Capture edge T gives out_valid=1 after edge T+WIDTH.
  - Latency is exactly WIDTH cycles; WIDTH=1 gives 1 cycle.
REQ-019 In DONE: out_valid=1, in_ready=0. diff and bout SHALL hold stable while out_ready=0, for any duration.
REQ-020 In DONE with out_ready=1 at an edge: return to IDLE. out_valid drops after that edge. diff/bout retain their values until the next result.
REQ-021 Result arithmetic:
  - diff = (a - b - borrow_in) mod 2^WIDTH.
  - bout=1 iff a < b + borrow_in (unsigned).
REQ-022 A simultaneous in_valid=1 during DONE SHALL NOT be accepted; acceptance happens only in IDLE, so throughput is at most one operation per WIDTH+2 cycles.
REQ-023 The counter SHALL be sized $clog2(WIDTH+1) and SHALL NOT wrap within one operation.

Reset
REQ-024 Asserting rst SHALL immediately, asynchronously and in any state:
  - force state to IDLE;
  - set in_ready=1 (combinational from IDLE) and out_valid=0;
  - clear diff, bout, borrow register and counter to 0.
REQ-025 Reset mid-RUN or mid-DONE SHALL abort the operation with no result output. After deassertion, the first valid edge accepts new operands normally.

Structure
REQ-026 Package serial_sub_pkg SHALL hold the state enum (IDLE, RUN, DONE) and constants SUB_HALF=0 and SUB_FULL=1.
REQ-027 Sub-module fs_cell (combinational 1-bit full subtractor: inputs x, y, bi; outputs d, bo) SHALL be instantiated once. In SUB_TYPE=0 mode, bi is tied to the registered borrow seeded with 0.
REQ-028 The shift/result and control logic SHALL reside in serial_subtractor. Estimated RTL is 150-250 lines.

Verification
REQ-029 WIDTH=8, SUB_TYPE=1: a=8'h05, b=8'h03, bin=0 -> out_valid exactly 8 cycles after capture; diff=8'h02, bout=0.
REQ-030 WIDTH=8: a=8'h00, b=8'h01, bin=0 -> diff=8'hFF, bout=1. Also a=8'h10, b=8'h0F, bin=1 -> diff=8'h00, bout=0.
REQ-031 SUB_TYPE=0: a=8'h10, b=8'h0F, bin=1 -> diff=8'h01, bout=0 (bin ignored).
REQ-032 Backpressure: hold out_ready=0 for 5 cycles in DONE, with in_valid=1 throughout:
  - diff/bout stay constant and in_ready stays 0;
  - after out_ready=1 for one edge, the block returns to IDLE and accepts the new operands on the next edge.
REQ-033 Pulse rst at RUN cycle 3 -> state IDLE, out_valid=0, diff=0, bout=0 immediately; the next operation a=8'hFF, b=8'h01 gives diff=8'hFE, bout=0.
REQ-034 WIDTH=1: all 8 combinations of a, b, bin -> 1-cycle latency, with diff and bout matching the truth table of REQ-017.
